latch_strobe_generator: RTL and testbench
=========================================

// Module: latch_strobe_generator
// PURPOSE
//  Upstream driver for the gated D latch (enable/data inputs).
//  - Synchronises and debounces a raw data switch and a raw "load" button.
//  - On each debounced button press, runs one timed load sequence: present data, wait SETUP,
//    raise enable for OPEN cycles, hold data HOLD cycles after enable falls.
//  - The latch therefore always sees a clean, setup/hold-safe transparent window.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive cycles a synced input must differ before the debounced value flips (>=1)
//  SETUP_CYCLES     2  cycles data is stable before enable rises (>=1)
//  OPEN_CYCLES      4  cycles enable is high (>=1)
//  HOLD_CYCLES      2  cycles data is stable after enable falls (>=1)
//  COUNT_WIDTH      8  width of the debounce and phase counters; every *_CYCLES value must be < 2**COUNT_WIDTH
// PORTS
//  clock       in   1  single system clock, rising edge
//  reset_      in   1  asynchronous, active-low reset
//  raw_data    in   1  asynchronous data switch
//  raw_button  in   1  asynchronous load button, active-high
//  enable      out  1  to latch enable; high only in OPEN
//  data        out  1  to latch data; frozen from SETUP entry through HOLD exit
//  busy        out  1  high in SETUP/OPEN/HOLD
//  dropped     out  1  one-cycle pulse: a press was detected while busy and was discarded
// BEHAVIOUR
//  - Reset (async, immediate): all flops 0.
//    - enable=0, data=0, busy=0, dropped=0, state=IDLE.
//    - Debounced values = 0; all counters = 0.
//    - Reset mid-sequence drops enable in the same instant; no sequence resumes after release.
//  - Sync: two-flop synchroniser per raw input.
//  - Debounce, per input:
//    - Counter increments each cycle while sync2 != debounced, else clears.
//    - When it would reach DEBOUNCE_CYCLES: debounced <= sync2 and counter <= 0.
//    - A mismatch shorter than DEBOUNCE_CYCLES cycles leaves the debounced value unchanged.
//  - Press = debounced button 0->1, registered edge detect.
//    - Holding the button produces no repeat; a release must debounce before the next press.
//  - FSM: IDLE -> SETUP -> OPEN -> HOLD -> IDLE.
//    - A phase counter loads 0 on each state entry.
//    - Exit from a state occurs at the edge where the counter equals (that state's CYCLES - 1).
//    - IDLE: on press, go to SETUP and load data <= debounced raw_data on the same edge.
//    - SETUP lasts SETUP_CYCLES, OPEN lasts OPEN_CYCLES, HOLD lasts HOLD_CYCLES; HOLD then returns to IDLE.
//  - Outputs are registered and decoded from the next state (no glitches).
//    - enable = (state==OPEN); busy = (state!=IDLE).
//    - data changes only on the IDLE->SETUP edge; otherwise it holds its last value, including in IDLE.
//  - Press while busy: no queueing; dropped=1 for exactly one cycle; sequence unaffected.
//  - Press detected on the same edge as HOLD->IDLE: treated as busy, so it is dropped.
//  - Debounced data changing in SETUP/OPEN/HOLD: ignored until the next sequence.
//  - Latency (raw_button high and steady from just before edge k; D = DEBOUNCE_CYCLES):
//    - Debounced button rises after edge k+D+1.
//    - busy and data update after edge k+D+2.
//    - enable rises after edge k+D+2+SETUP_CYCLES.
//    - busy falls after edge k+D+2+SETUP_CYCLES+OPEN_CYCLES+HOLD_CYCLES.
// TESTING
//  1. Reset: assert reset_ mid-OPEN -> enable, busy, data go to 0 immediately; after release, state=IDLE.
//  2. Defaults, raw_data=1, button rises before edge k -> busy=1, data=1 after edge k+6;
//     enable=1 after edges k+8..k+11, 0 after edge k+12; busy=0 after edge k+14.
//  3. Glitch: 3-cycle raw_button pulse with D=4 -> debounced button stays 0; enable, busy, dropped stay 0.
//  4. Bounce: button toggles every cycle for 10 cycles, then held high -> exactly one sequence;
//     enable high for exactly 4 cycles.
//  5. Press during OPEN (release, re-press) -> dropped=1 for one cycle; enable window unchanged at 4 cycles.
//  6. Toggle raw_data during SETUP/OPEN/HOLD -> data constant; the next press loads the new debounced value.

Source files
------------

// File: rtl/latch_strobe_generator_if.sv
// Signal bundle between the switch/button front end, the strobe generator and the gated D latch.
// The master side drives the raw inputs; the slave (the generator) drives the latch-facing outputs.
interface latch_strobe_generator_if;
  logic raw_data;
  logic raw_button;
  logic enable;
  logic data;
  logic busy;
  logic dropped;

  modport master (
    output raw_data, raw_button,
    input  enable, data, busy, dropped
  );

  modport slave (
    input  raw_data, raw_button,
    output enable, data, busy, dropped
  );
endinterface

// File: rtl/latch_strobe_generator.sv
// Synchronises and debounces a data switch and a load button, then drives a gated D latch
// through a timed setup / open / hold window on every debounced button press.
module latch_strobe_generator #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned OPEN_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES     = 2,
  parameter int unsigned COUNT_WIDTH     = 8
) (
  input  logic                     clock,
  input  logic                     reset_,
  latch_strobe_generator_if.slave  lsg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] DEB_LAST   = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] SETUP_LAST = COUNT_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] OPEN_LAST  = COUNT_WIDTH'(OPEN_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] HOLD_LAST  = COUNT_WIDTH'(HOLD_CYCLES - 1);

  // Bit 0 carries the button, bit 1 the data switch, through sync and debounce.
  localparam int BTN = 0;
  localparam int DAT = 1;

  logic [1:0]                  sync1_q, sync1_d;
  logic [1:0]                  sync2_q, sync2_d;
  logic [1:0]                  deb_q, deb_d;
  logic [1:0][COUNT_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
  logic                        btn_prev_q, btn_prev_d;
  logic                        press;

  logic [1:0]                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]      phase_q, phase_d;
  logic                        enable_q, enable_d;
  logic                        data_q, data_d;
  logic                        busy_q, busy_d;
  logic                        dropped_q, dropped_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sync1_d    = {lsg.raw_data, lsg.raw_button};
    sync2_d    = sync1_q;
    btn_prev_d = deb_q[BTN];
    for (int i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  assign press = deb_q[BTN] & ~btn_prev_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (press) begin
          state_d = ST_SETUP;
          data_d  = deb_q[DAT];
        end
      end
      ST_SETUP: if (phase_q == SETUP_LAST) begin
        state_d = ST_OPEN;
        phase_d = '0;
      end
      ST_OPEN: if (phase_q == OPEN_LAST) begin
        state_d = ST_HOLD;
        phase_d = '0;
      end
      ST_HOLD: if (phase_q == HOLD_LAST) begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
    // A press on the HOLD->IDLE edge still sees state_q==HOLD, so it is dropped.
    dropped_d = press && (state_q != ST_IDLE);
    enable_d  = (state_d == ST_OPEN);
    busy_d    = (state_d != ST_IDLE);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_cnt_q  <= '0;
      btn_prev_q <= 1'b0;
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      enable_q   <= 1'b0;
      data_q     <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      enable_q   <= enable_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  assign lsg.enable  = enable_q;
  assign lsg.data    = data_q;
  assign lsg.busy    = busy_q;
  assign lsg.dropped = dropped_q;

endmodule

// File: tb/tb_latch_strobe_generator.sv
// Scoreboard bench for latch_strobe_generator: a reference model predicts load sequences and
// dropped presses from the raw inputs; a monitor checks the DUT outputs against those predictions.
module tb_latch_strobe_generator;

  localparam int D = 4;
  localparam int S = 2;
  localparam int O = 4;
  localparam int H = 2;

  logic clock  = 1'b0;
  logic reset_ = 1'b0;

  latch_strobe_generator_if lsg_if ();

  latch_strobe_generator #(
    .DEBOUNCE_CYCLES (D),
    .SETUP_CYCLES    (S),
    .OPEN_CYCLES     (O),
    .HOLD_CYCLES     (H),
    .COUNT_WIDTH     (8)
  ) dut (
    .clock  (clock),
    .reset_ (reset_),
    .lsg    (lsg_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_m    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_m);
  endtask

  // ---------------- reference model ----------------
  // A debounced input flips once the last D synchronised samples all disagree with it;
  // the synchroniser makes the sample taken two edges ago the newest one the debouncer sees.
  bit btn_hist[$];
  bit dat_hist[$];
  bit m_deb_btn, m_deb_btn_prev, m_deb_dat;
  int seq_end;
  int exp_seq_start[$];
  bit exp_seq_data[$];
  int exp_drop[$];

  function automatic bit debounce(input bit hist[$], input bit cur);
    int  l = hist.size() - 1;
    bit  all_differ = 1'b1;
    for (int j = 2; j <= D + 1; j++)
      if (hist[l - j] == cur) all_differ = 1'b0;
    return all_differ ? ~cur : cur;
  endfunction

  always @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      btn_hist.delete();
      dat_hist.delete();
      for (int j = 0; j < D + 2; j++) begin
        btn_hist.push_back(1'b0);
        dat_hist.push_back(1'b0);
      end
      m_deb_btn      = 1'b0;
      m_deb_btn_prev = 1'b0;
      m_deb_dat      = 1'b0;
      seq_end        = -1;
      exp_seq_start.delete();
      exp_seq_data.delete();
      exp_drop.delete();
    end else begin
      cyc_m++;
      if (m_deb_btn && !m_deb_btn_prev) begin
        if (cyc_m > seq_end) begin
          exp_seq_start.push_back(cyc_m);
          exp_seq_data.push_back(m_deb_dat);
          seq_end = cyc_m + S + O + H;
        end else begin
          exp_drop.push_back(cyc_m);
        end
      end
      m_deb_btn_prev = m_deb_btn;
      btn_hist.push_back(lsg_if.raw_button);
      dat_hist.push_back(lsg_if.raw_data);
      void'(btn_hist.pop_front());
      void'(dat_hist.pop_front());
      m_deb_btn = debounce(btn_hist, m_deb_btn);
      m_deb_dat = debounce(dat_hist, m_deb_dat);
    end
  end

  // ---------------- monitor ----------------
  bit busy_prev = 1'b0;
  bit in_seq    = 1'b0;
  bit cur_data  = 1'b0;
  bit last_data = 1'b0;
  int cur_start = 0;

  always @(negedge clock) begin
    if (!reset_) begin
      busy_prev = 1'b0;
      in_seq    = 1'b0;
      last_data = 1'b0;
    end else begin
      if (lsg_if.dropped) begin
        if (exp_drop.size() == 0) check("unexpected_dropped", 1, 0);
        else check("dropped_cycle", cyc_m, exp_drop.pop_front());
      end
      if (lsg_if.busy && !busy_prev && !in_seq) begin
        if (exp_seq_start.size() == 0) begin
          check("unexpected_busy", 1, 0);
        end else begin
          cur_start = exp_seq_start.pop_front();
          cur_data  = exp_seq_data.pop_front();
          in_seq    = 1'b1;
          check("start_cycle", cyc_m, cur_start);
        end
      end
      if (in_seq) begin
        check("busy", lsg_if.busy, 32'(cyc_m < cur_start + S + O + H));
        check("enable", lsg_if.enable,
              32'(cyc_m >= cur_start + S && cyc_m < cur_start + S + O));
        check("data_frozen", lsg_if.data, cur_data);
        if (!lsg_if.busy) begin
          in_seq    = 1'b0;
          last_data = cur_data;
        end
      end else begin
        check("idle_enable", lsg_if.enable, 0);
        check("idle_data", lsg_if.data, last_data);
      end
      busy_prev = lsg_if.busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit b, input bit d, input int n);
    lsg_if.raw_button = b;
    lsg_if.raw_data   = d;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  left;
    bit  rb, rd;
    lsg_if.raw_button = 1'b0;
    lsg_if.raw_data   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_enable",  lsg_if.enable,  0);
    check("rst_busy",    lsg_if.busy,    0);
    check("rst_data",    lsg_if.data,    0);
    check("rst_dropped", lsg_if.dropped, 0);
    reset_ = 1'b1;

    // Plain press with data=1, then release.
    drive(1, 1, 20);
    drive(0, 1, 12);
    // Glitch shorter than the debounce window.
    drive(1, 1, 3);
    drive(0, 1, 15);
    // Bouncing button settling high: one sequence only.
    for (int i = 0; i < 10; i++) drive(i % 2 == 0, 0, 1);
    drive(1, 0, 20);
    drive(0, 0, 12);
    // Minimal release/re-press lands on the HOLD->IDLE edge and is dropped.
    drive(1, 1, 4);
    drive(0, 1, 4);
    drive(1, 1, 20);
    drive(0, 1, 12);
    // One cycle longer release: re-press starts a fresh sequence right after IDLE.
    drive(1, 0, 4);
    drive(0, 0, 5);
    drive(1, 0, 20);
    drive(0, 0, 12);
    // Data changes mid-sequence are ignored; the next press loads the new value.
    drive(1, 0, 8);
    drive(1, 1, 12);
    drive(0, 1, 12);
    drive(1, 1, 20);
    drive(0, 1, 12);

    // Reset in the middle of OPEN.
    drive(1, 0, 1);
    drive(0, 0, 12);
    lsg_if.raw_button = 1'b1;
    lsg_if.raw_data   = 1'b1;
    for (int i = 0; i < 40 && !lsg_if.enable; i++) begin
      @(posedge clock);
      #1;
    end
    check("reached_open", lsg_if.enable, 1);
    repeat (2) @(posedge clock);
    #2;
    reset_ = 1'b0;
    #1;
    check("midopen_rst_enable", lsg_if.enable, 0);
    check("midopen_rst_busy",   lsg_if.busy,   0);
    check("midopen_rst_data",   lsg_if.data,   0);
    lsg_if.raw_button = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_ = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("no_resume_busy",   lsg_if.busy,   0);
    check("no_resume_enable", lsg_if.enable, 0);

    // Randomised button segments with a wandering data switch.
    left = 0;
    rb   = 1'b0;
    rd   = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (left == 0) begin
        rb   = 1'($urandom_range(0, 1));
        left = $urandom_range(1, 14);
      end
      left--;
      if ($urandom_range(0, 5) == 0) rd = ~rd;
      drive(rb, rd, 1);
    end
    drive(0, 0, 40);

    check("pending_sequences", exp_seq_start.size(), 0);
    check("pending_drops",     exp_drop.size(),      0);
    check("final_idle_busy",   lsg_if.busy,          0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
